// File: rtl/usb_pkg.sv
// usb_pkg: shared FSM state numbering and default timing constants
// for the FT245-style USB FIFO controllers (receive and transmit).
package usb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CHECK   = 4'd1,
        ST_SETUP   = 4'd2,
        ST_STROBE  = 4'd3,
        ST_HOLD    = 4'd4,
        ST_RECOVER = 4'd5,
        ST_SIWU    = 4'd6
    } state_t;

    localparam int DEF_DEPTH       = 16;
    localparam int DEF_SETUP_CYC   = 2;
    localparam int DEF_WR_CYC      = 4;
    localparam int DEF_HOLD_CYC    = 2;
    localparam int DEF_RECOVER_CYC = 6;
    localparam int DEF_FLUSH_IDLE  = 1024;

    function automatic int max4(input int a, input int b,
                                input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/usb_tx_fifo.sv
// usb_tx_fifo: synchronous first-word-fall-through byte FIFO;
// dout is valid whenever empty is low.
module usb_tx_fifo #(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push,
    input  logic        pop,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rp];

    // storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

    // pointers wrap naturally; count tracks occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/usb_output.sv
// usb_output: transmit controller for the FT245-style USB FIFO chip.
// Define USB_OUTPUT_SIWU_EN to enable the idle SI/WU flush pulse.
module usb_output
    import usb_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int SETUP_CYC   = DEF_SETUP_CYC,
    parameter int WR_CYC      = DEF_WR_CYC,
    parameter int HOLD_CYC    = DEF_HOLD_CYC,
    parameter int RECOVER_CYC = DEF_RECOVER_CYC,
    parameter int FLUSH_IDLE  = DEF_FLUSH_IDLE
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] data,
    output logic       data_oe,
    output logic       wr,
    input  logic       txe,
    output logic       siwu,
    output logic       busy,
    output logic [3:0] state
);

    localparam int MAXC = max4(SETUP_CYC, WR_CYC, HOLD_CYC, RECOVER_CYC);
    localparam int CW   = $clog2(MAXC) + 1;
    localparam int AW   = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("usb_output: DEPTH must be a power of two >= 2");
    end
    if (MAXC < 1 || SETUP_CYC < 1 || WR_CYC < 1 ||
        HOLD_CYC < 1 || RECOVER_CYC < 1) begin : g_bad_timing
        $error("usb_output: timing parameters must be >= 1");
    end
    if (FLUSH_IDLE < 1) begin : g_bad_flush
        $error("usb_output: FLUSH_IDLE must be >= 1");
    end

    state_t        st;
    logic [CW-1:0] cnt;
    logic          txe_m;
    logic          txe_s;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [7:0]    head;
    logic [AW:0]   count;

    assign in_ready = ~full;
    assign push     = in_valid & in_ready;
    assign pop      = (st == ST_CHECK) && !txe_s;
    assign busy     = (count != '0) || (st != ST_IDLE);
    assign state    = st;

    // two-flop synchronizer; resets to "chip not ready"
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            txe_m <= 1'b1;
            txe_s <= 1'b1;
        end else begin
            txe_m <= txe;
            txe_s <= txe_m;
        end
    end

    usb_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (in),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

`ifdef USB_OUTPUT_SIWU_EN
    localparam int IW = $clog2(FLUSH_IDLE + 1);
    logic          siwu_q;
    logic          written;
    logic [IW-1:0] idle_cnt;
    assign siwu = siwu_q;
`else
    assign siwu = 1'b1;
`endif

    // write-cycle sequencer with registered pad outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st      <= ST_IDLE;
            cnt     <= '0;
            data    <= '0;
            data_oe <= 1'b0;
            wr      <= 1'b0;
`ifdef USB_OUTPUT_SIWU_EN
            siwu_q   <= 1'b1;
            written  <= 1'b0;
            idle_cnt <= '0;
`endif
        end else begin
            case (st)
                ST_IDLE: begin
                    if (!empty && !txe_s) begin
                        st <= ST_CHECK;
`ifdef USB_OUTPUT_SIWU_EN
                        idle_cnt <= '0;
                    end else if (written && empty && !push) begin
                        if (idle_cnt == IW'(FLUSH_IDLE - 1)) begin
                            st       <= ST_SIWU;
                            siwu_q   <= 1'b0;
                            cnt      <= CW'(WR_CYC - 1);
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end else begin
                        idle_cnt <= '0;
`endif
                    end
                end
                ST_CHECK: begin
                    if (!txe_s) begin
                        data    <= head;
                        data_oe <= 1'b1;
                        cnt     <= CW'(SETUP_CYC - 1);
                        st      <= ST_SETUP;
`ifdef USB_OUTPUT_SIWU_EN
                        written <= 1'b1;
`endif
                    end else begin
                        st <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        wr  <= 1'b1;
                        cnt <= CW'(WR_CYC - 1);
                        st  <= ST_STROBE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_STROBE: begin
                    if (cnt == '0) begin
                        wr  <= 1'b0;
                        cnt <= CW'(HOLD_CYC - 1);
                        st  <= ST_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        data_oe <= 1'b0;
                        cnt     <= CW'(RECOVER_CYC - 1);
                        st      <= ST_RECOVER;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RECOVER: begin
                    if (cnt == '0) st <= ST_IDLE;
                    else           cnt <= cnt - 1'b1;
                end
`ifdef USB_OUTPUT_SIWU_EN
                ST_SIWU: begin
                    if (cnt == '0) begin
                        siwu_q  <= 1'b1;
                        written <= 1'b0;
                        st      <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`endif
                default: begin
                    st      <= ST_IDLE;
                    wr      <= 1'b0;
                    data_oe <= 1'b0;
`ifdef USB_OUTPUT_SIWU_EN
                    siwu_q  <= 1'b1;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_output.sv
// tb_usb_output: directed bench for usb_output with a cycle model
// derived from the write-window timing, plus literal spot checks.
`timescale 1ns/1ps
module tb_usb_output;

    localparam int DEPTH = 16;
    localparam int S     = 2;
    localparam int W     = 4;
    localparam int H     = 2;
    localparam int R     = 6;
    localparam int FI    = 1024;
    localparam int TOTAL = S + W + H + R;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] din = 8'h00;
    logic       in_valid = 1'b0;
    logic       txe = 1'b0;
    logic       in_ready;
    logic [7:0] data;
    logic       data_oe;
    logic       wr;
    logic       siwu;
    logic       busy;
    logic [3:0] state;

    usb_output #(
        .DEPTH(DEPTH), .SETUP_CYC(S), .WR_CYC(W),
        .HOLD_CYC(H), .RECOVER_CYC(R), .FLUSH_IDLE(FI)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in(din), .in_valid(in_valid),
        .in_ready(in_ready), .data(data), .data_oe(data_oe), .wr(wr),
        .txe(txe), .siwu(siwu), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // model: mode 0 idle, 1 check, 2 write window (k = edges since
    // the pop), 3 flush pulse
    logic [7:0] q[$];
    int         mode;
    int         k;
    logic [7:0] last;
    bit         ts1;
    bit         ts2;
    bit         written;
    int         idle_n;

    task automatic model_reset();
        q.delete();
        mode = 0; k = 0; last = 8'h00;
        ts1 = 1'b1; ts2 = 1'b1;
        written = 1'b0; idle_n = 0;
    endtask

    task automatic model_step();
        bit pushed;
        pushed = in_valid && (q.size() < DEPTH);
        case (mode)
            0: begin
                if (q.size() != 0 && !ts2) begin
                    mode = 1;
                    idle_n = 0;
                end
`ifdef USB_OUTPUT_SIWU_EN
                else if (written && q.size() == 0 && !pushed) begin
                    idle_n++;
                    if (idle_n == FI) begin
                        mode = 3; k = 0; idle_n = 0;
                    end
                end else idle_n = 0;
`endif
            end
            1: begin
                if (!ts2) begin
                    last = q.pop_front();
                    mode = 2; k = 0; written = 1'b1;
                end else mode = 0;
            end
            2: begin
                k++;
                if (k == TOTAL) mode = 0;
            end
            3: begin
                k++;
                if (k == W) begin mode = 0; written = 1'b0; end
            end
            default: mode = 0;
        endcase
        if (pushed) q.push_back(din);
        ts2 = ts1;
        ts1 = txe;
    endtask

    function automatic int exp_state();
        if (mode == 0) return 0;
        if (mode == 1) return 1;
        if (mode == 3) return 6;
        if (k < S) return 2;
        if (k < S + W) return 3;
        if (k < S + W + H) return 4;
        return 5;
    endfunction

    // single compare process; inputs change only just after posedge
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!reset_n) model_reset();
            chk("in_ready", in_ready, q.size() < DEPTH);
            chk("busy", busy, q.size() != 0 || mode != 0);
            chk("wr", wr, mode == 2 && k >= S && k < S + W);
            chk("data_oe", data_oe, mode == 2 && k < S + W + H);
            chk("data", data, last);
            chk("state", state, exp_state());
            chk("siwu", siwu, mode != 3);
            if (reset_n) model_step();
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push1(input logic [7:0] b);
        din = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_wr(input string name, input int bound,
                           output int n);
        n = 0;
        while (wr !== 1'b1 && n < bound) begin step(); n++; end
        if (wr !== 1'b1) begin
            checks++; errors++;
            $display("FAIL %s: wr=%b required 1 within %0d cycles",
                     name, wr, bound);
        end
    endtask

    task automatic wait_low(input int bound);
        int n;
        n = 0;
        while (wr === 1'b1 && n < bound) begin step(); n++; end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 600) begin step(); n++; end
        chk("idle_timeout", busy, 0);
        step(); step();
    endtask

    task automatic count_rises(input int len, output int rises);
        logic prev;
        rises = 0;
        prev = wr;
        for (int i = 0; i < len; i++) begin
            step();
            if (wr && !prev) rises++;
            prev = wr;
        end
    endtask

    int n;
    int m;
    int rises;
    int t_rise[16];

    initial begin
        // reset state
        step(); step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_data", data, 0);
        chk("rst_data_oe", data_oe, 0);
        chk("rst_wr", wr, 0);
        chk("rst_siwu", siwu, 1);
        chk("rst_busy", busy, 0);
        chk("rst_state", state, 0);
        reset_n = 1'b1;
        txe = 1'b0;
        step(); step(); step();

        // single byte: latency, pulse width, hold after strobe
        push1(8'hA5);
        wait_wr("t1_rise", 40, n);
        chk("t1_latency", n, 4);
        chk("t1_data", data, 8'hA5);
        chk("t1_oe", data_oe, 1);
        m = 0;
        while (wr === 1'b1 && m < 20) begin step(); m++; end
        chk("t1_wr_width", m, 4);
        m = 0;
        while (data_oe === 1'b1 && m < 20) begin step(); m++; end
        chk("t1_hold", m, 2);
        count_rises(40, rises);
        chk("t1_one_pulse", rises, 0);
        wait_idle();

        // fill while chip not ready, then drain in order
        txe = 1'b1;
        step(); step(); step();
        in_valid = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            din = 8'(i);
            step();
        end
        din = 8'hEE;
        chk("t2_full", in_ready, 0);
        step();
        in_valid = 1'b0;
        count_rises(10, rises);
        chk("t2_no_wr", rises, 0);
        chk("t2_busy", busy, 1);
        txe = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wait_wr("t2_rise", 60, n);
            t_rise[i] = cyc;
            chk("t2_order", data, i + 1);
            if (i > 0) chk("t2_spacing", t_rise[i] - t_rise[i-1], 16);
            wait_low(20);
        end
        wait_idle();
        chk("t2_empty", in_ready, 1);

        // one-cycle TXE# high seen during CHECK
        din = 8'h5A;
        in_valid = 1'b1;
        txe = 1'b1;
        step();
        in_valid = 1'b0;
        txe = 1'b0;
        chk("t3_idle", state, 0);
        step();
        chk("t3_check", state, 1);
        step();
        chk("t3_back_idle", state, 0);
        chk("t3_no_oe", data_oe, 0);
        wait_wr("t3_rise", 40, n);
        chk("t3_retry_latency", n, 4);
        chk("t3_data", data, 8'h5A);
        wait_idle();

        // TXE# rises mid-strobe
        push1(8'h11);
        push1(8'h22);
        wait_wr("t4_rise1", 40, n);
        chk("t4_data1", data, 8'h11);
        step();
        txe = 1'b1;
        m = 1;
        while (wr === 1'b1 && m < 20) begin step(); m++; end
        chk("t4_wr_width", m, 4);
        count_rises(40, rises);
        chk("t4_wait", rises, 0);
        chk("t4_busy", busy, 1);
        txe = 1'b0;
        wait_wr("t4_rise2", 40, n);
        chk("t4_data2", data, 8'h22);
        wait_idle();

        // async reset mid-strobe
        push1(8'h77);
        push1(8'h78);
        wait_wr("t5_rise", 40, n);
        step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_wr", wr, 0);
        chk("t5_oe", data_oe, 0);
        chk("t5_state", state, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ready", in_ready, 1);
        step(); step();
        reset_n = 1'b1;
        push1(8'h3C);
        wait_wr("t5_rise2", 40, n);
        chk("t5_data", data, 8'h3C);
        m = 0;
        while (busy === 1'b1 && m < 60) begin step(); m++; end
        chk("t5_done", busy, 0);
`ifdef USB_OUTPUT_SIWU_EN
        m = 0;
        while (siwu === 1'b1 && m < FI + 100) begin step(); m++; end
        chk("t6_flush_delay", m, FI);
        m = 0;
        while (siwu === 1'b0 && m < 20) begin step(); m++; end
        chk("t6_siwu_width", m, W);
        count_rises(20, rises);
        chk("t6_no_wr", rises, 0);
`else
        count_rises(40, rises);
        chk("t5_no_stale", rises, 0);
        chk("t6_siwu_idle", siwu, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
